// File: rtl/rcounter_ctrl.sv
// Run-control sequencer for the countdown timer: validates and latches the BCD preset,
// sequences IDLE/RUN/PAUSE/DONE, gates the core enable at expiry and times the alarm.
module rcounter_ctrl #(
  parameter int unsigned ALARM_CYCLES = 100
) (
  input  logic       clk_core,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] min_set,
  input  logic [7:0] sec_set,
  input  logic [7:0] ms_10_set,
  input  logic       start_pause,
  input  logic       clear,
  input  logic       time_out,
  output logic [7:0] min_pre,
  output logic [7:0] sec_pre,
  output logic [7:0] ms_10_pre,
  output logic       core_en,
  output logic       core_rst,
  output logic [1:0] state_o,
  output logic       alarm,
  output logic       load_err
);

  localparam int unsigned CntW = (ALARM_CYCLES > 1) ? $clog2(ALARM_CYCLES) : 1;
  localparam logic [CntW-1:0] CntInit = CntW'(ALARM_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRun   = 2'b01,
    StPause = 2'b10,
    StDone  = 2'b11
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      min_q, sec_q, ms_q;
  logic            core_rst_q;
  logic            load_err_q;
  logic            alarm_q;
  logic [CntW-1:0] alarm_cnt_q;
  logic            preset_ok;
  logic            preset_zero;
  logic            load_take;

  assign preset_ok = (min_set[7:4] <= 4'd9) && (min_set[3:0] <= 4'd9) &&
                     (sec_set[7:4] <= 4'd5) && (sec_set[3:0] <= 4'd9) &&
                     (ms_10_set[7:4] <= 4'd9) && (ms_10_set[3:0] <= 4'd9);
  assign preset_zero = ({min_q, sec_q, ms_q} == 24'd0);
  assign load_take   = (state_q == StIdle) && load && !clear;

  always_ff @(posedge clk_core or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // A load in the same cycle as start_pause wins; the start is dropped.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle:  if (start_pause && !load && !preset_zero) state_d = StRun;
        StRun: begin
          if (time_out) begin
            state_d = StDone;
          end else if (start_pause) begin
            state_d = StPause;
          end
        end
        StPause: if (start_pause) state_d = StRun;
        StDone:  if (start_pause) state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    core_en = (state_q == StRun) && !time_out;
    state_o = state_q;
  end

  always_ff @(posedge clk_core or posedge rst) begin
    if (rst) begin
      min_q      <= 8'd0;
      sec_q      <= 8'd0;
      ms_q       <= 8'd0;
      core_rst_q <= 1'b1;
      load_err_q <= 1'b0;
    end else begin
      core_rst_q <= (state_d == StIdle);
      load_err_q <= load_take && !preset_ok;
      if (load_take && preset_ok) begin
        min_q <= min_set;
        sec_q <= sec_set;
        ms_q  <= ms_10_set;
      end
    end
  end

  // Alarm stays high until the counter has sat at zero for one edge: ALARM_CYCLES cycles total.
  always_ff @(posedge clk_core or posedge rst) begin
    if (rst) begin
      alarm_q     <= 1'b0;
      alarm_cnt_q <= '0;
    end else if (state_d == StDone && state_q != StDone) begin
      alarm_q     <= 1'b1;
      alarm_cnt_q <= CntInit;
    end else if (state_d != StDone) begin
      alarm_q     <= 1'b0;
      alarm_cnt_q <= '0;
    end else if (alarm_cnt_q == '0) begin
      alarm_q <= 1'b0;
    end else begin
      alarm_cnt_q <= alarm_cnt_q - 1'b1;
    end
  end

  assign min_pre   = min_q;
  assign sec_pre   = sec_q;
  assign ms_10_pre = ms_q;
  assign core_rst  = core_rst_q;
  assign load_err  = load_err_q;
  assign alarm     = alarm_q;

endmodule
